// File: rtl/timer_a_counter_if.sv
// Timer_A counter bus: register-file controls in, count and event pulses out.
// Signal names follow the Timer_A register/field names used by the register file.
interface timer_a_counter_if #(
    parameter int WIDTH = 16
);
    logic [1:0]       MC;
    logic [1:0]       ID;
    logic [2:0]       IDEX;
    logic             TACLR;
    logic [WIDTH-1:0] TACCR0;
    logic             wTAR;
    logic [WIDTH-1:0] TARin;
    logic [WIDTH-1:0] TAR;
    logic             EQU0;
    logic             TAIFGset;
    logic             DIR;

    modport master (
        output MC, ID, IDEX, TACLR, TACCR0, wTAR, TARin,
        input  TAR, EQU0, TAIFGset, DIR
    );

    modport slave (
        input  MC, ID, IDEX, TACLR, TACCR0, wTAR, TARin,
        output TAR, EQU0, TAIFGset, DIR
    );
endinterface

// File: rtl/timer_a_counter.sv
// Timer_A main counter (TAR) with two-stage input divider and stop/up/continuous/up-down modes.
// Outputs registered, updated on the divided tick edge; no backpressure, strobes accepted every cycle.
module timer_a_counter #(
    parameter int WIDTH = 16
) (
    input  logic               TimerClock,
    input  logic               reset,
    timer_a_counter_if.slave   bus
);
    localparam logic [1:0] MC_STOP = 2'd0;
    localparam logic [1:0] MC_UP   = 2'd1;
    localparam logic [1:0] MC_CONT = 2'd2;
    localparam logic [1:0] MC_UPDN = 2'd3;

    logic [WIDTH-1:0] tar_q;
    logic             dir_q;
    logic             equ0_q;
    logic             taifg_q;
    logic [2:0]       div1_q;
    logic [2:0]       div2_q;

    logic [2:0]       div1_max;
    logic             wrap1;
    logic             wrap2;
    logic             tick;

    logic [WIDTH-1:0] tar_inc;
    logic [WIDTH-1:0] tar_dec;
    logic [WIDTH-1:0] nxt_tar;
    logic             nxt_dir;
    logic             nxt_ifg;

    always_comb begin
        div1_max = 3'd0;
        case (bus.ID)
            2'd0: div1_max = 3'd0;
            2'd1: div1_max = 3'd1;
            2'd2: div1_max = 3'd3;
            2'd3: div1_max = 3'd7;
            default: div1_max = 3'd0;
        endcase
    end

    assign wrap1 = (div1_q == div1_max);
    assign wrap2 = (div2_q == bus.IDEX);
    assign tick  = wrap1 & wrap2;

    assign tar_inc = tar_q + 1'b1;
    assign tar_dec = tar_q - 1'b1;

    always_comb begin
        nxt_tar = tar_q;
        nxt_dir = dir_q;
        nxt_ifg = 1'b0;
        case (bus.MC)
            MC_UP: begin
                nxt_dir = 1'b1;
                nxt_tar = (tar_q >= bus.TACCR0) ? '0 : tar_inc;
                // A zero period holds TAR at 0 and is not a rollover
                nxt_ifg = (tar_q == bus.TACCR0) && (bus.TACCR0 != '0);
            end
            MC_CONT: begin
                nxt_dir = 1'b1;
                nxt_tar = tar_inc;
                nxt_ifg = &tar_q;
            end
            MC_UPDN: begin
                if (bus.TACCR0 == '0) begin
                    nxt_tar = '0;
                    nxt_dir = 1'b1;
                end else if (dir_q && (tar_q < bus.TACCR0)) begin
                    nxt_tar = tar_inc;
                    nxt_dir = (tar_inc != bus.TACCR0);
                end else begin
                    // Down step, also taken when TACCR0 was lowered below TAR
                    nxt_tar = tar_dec;
                    nxt_dir = (tar_dec == '0);
                    nxt_ifg = (tar_dec == '0);
                end
            end
            default: begin
                nxt_tar = tar_q;
                nxt_dir = dir_q;
                nxt_ifg = 1'b0;
            end
        endcase
    end

    always_ff @(posedge TimerClock or posedge reset) begin
        if (reset) begin
            tar_q   <= '0;
            dir_q   <= 1'b1;
            equ0_q  <= 1'b0;
            taifg_q <= 1'b0;
            div1_q  <= 3'd0;
            div2_q  <= 3'd0;
        end else begin
            equ0_q  <= 1'b0;
            taifg_q <= 1'b0;
            if (bus.TACLR) begin
                tar_q  <= '0;
                dir_q  <= 1'b1;
                div1_q <= 3'd0;
                div2_q <= 3'd0;
            end else if (bus.wTAR) begin
                tar_q <= bus.TARin;
            end else if (bus.MC != MC_STOP) begin
                div1_q <= wrap1 ? 3'd0 : div1_q + 3'd1;
                if (wrap1) begin
                    div2_q <= wrap2 ? 3'd0 : div2_q + 3'd1;
                end
                if (tick) begin
                    tar_q   <= nxt_tar;
                    dir_q   <= nxt_dir;
                    equ0_q  <= (nxt_tar == bus.TACCR0);
                    taifg_q <= nxt_ifg;
                end
            end
        end
    end

    assign bus.TAR      = tar_q;
    assign bus.DIR      = dir_q;
    assign bus.EQU0     = equ0_q;
    assign bus.TAIFGset = taifg_q;
endmodule

// File: tb/tb_timer_a_counter.sv
// Bench for timer_a_counter: directed scenarios plus randomized traffic against a cycle-level model.
// The model tracks the divider as a single phase counter over the full divide period.
module tb_timer_a_counter;
    logic TimerClock;
    logic reset;

    timer_a_counter_if #(.WIDTH(16)) bus ();

    timer_a_counter #(.WIDTH(16)) dut (
        .TimerClock (TimerClock),
        .reset      (reset),
        .bus        (bus)
    );

    int errors = 0;
    int checks = 0;

    int m_tar;
    int m_ph;
    bit m_dir;
    bit e_equ;
    bit e_ifg;

    initial TimerClock = 1'b0;
    always #5 TimerClock = ~TimerClock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_tar = 0;
        m_dir = 1'b1;
        m_ph  = 0;
        e_equ = 1'b0;
        e_ifg = 1'b0;
    endtask

    // Advance the model by one edge using the inputs currently applied, then clock the DUT.
    task automatic step();
        int  per;
        int  ccr;
        int  nxt;
        bit  tk;
        per   = (1 << int'(bus.ID)) * (int'(bus.IDEX) + 1);
        ccr   = int'(bus.TACCR0);
        e_equ = 1'b0;
        e_ifg = 1'b0;
        if (bus.TACLR) begin
            m_tar = 0;
            m_dir = 1'b1;
            m_ph  = 0;
        end else if (bus.wTAR) begin
            m_tar = int'(bus.TARin);
        end else if (bus.MC != 2'd0) begin
            tk   = (m_ph == per - 1);
            m_ph = tk ? 0 : m_ph + 1;
            if (tk) begin
                nxt = m_tar;
                case (bus.MC)
                    2'd1: begin
                        m_dir = 1'b1;
                        nxt   = (m_tar >= ccr) ? 0 : m_tar + 1;
                        e_ifg = (m_tar == ccr) && (ccr != 0);
                    end
                    2'd2: begin
                        m_dir = 1'b1;
                        nxt   = (m_tar + 1) % 65536;
                        e_ifg = (nxt == 0);
                    end
                    default: begin
                        if (ccr == 0) begin
                            nxt   = 0;
                            m_dir = 1'b1;
                        end else if (m_dir && m_tar < ccr) begin
                            nxt = m_tar + 1;
                            if (nxt == ccr) m_dir = 1'b0;
                        end else begin
                            nxt   = (m_tar + 65535) % 65536;
                            m_dir = 1'b0;
                            if (nxt == 0) begin
                                m_dir = 1'b1;
                                e_ifg = 1'b1;
                            end
                        end
                    end
                endcase
                e_equ = (nxt == ccr);
                m_tar = nxt;
            end
        end
        @(posedge TimerClock);
        #1;
    endtask

    task automatic start(input logic [1:0] mc, input logic [1:0] id, input logic [2:0] idex,
                         input logic [15:0] ccr);
        bus.MC     = mc;
        bus.ID     = id;
        bus.IDEX   = idex;
        bus.TACCR0 = ccr;
        bus.TACLR  = 1'b1;
        step();
        bus.TACLR  = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus.MC     = 2'd0;
        bus.ID     = 2'd0;
        bus.IDEX   = 3'd0;
        bus.TACLR  = 1'b0;
        bus.TACCR0 = 16'd0;
        bus.wTAR   = 1'b0;
        bus.TARin  = 16'd0;
        model_reset();
        #23;
        checks++; if (bus.TAR !== 16'd0) begin errors++; $display("FAIL reset_tar: got %h required 0000", bus.TAR); end
        checks++; if (bus.DIR !== 1'b1) begin errors++; $display("FAIL reset_dir: got %b required 1", bus.DIR); end
        checks++; if (bus.EQU0 !== 1'b0) begin errors++; $display("FAIL reset_equ0: got %b required 0", bus.EQU0); end
        checks++; if (bus.TAIFGset !== 1'b0) begin errors++; $display("FAIL reset_taifg: got %b required 0", bus.TAIFGset); end
        @(negedge TimerClock);
        reset = 1'b0;
    endtask

    task automatic test_up();
        start(2'd1, 2'd0, 3'd0, 16'd3);
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (bus.TAR !== 16'((i + 1) % 4)) begin errors++; $display("FAIL up_tar step %0d: got %0d required %0d", i, bus.TAR, (i + 1) % 4); end
            checks++; if (bus.EQU0 !== (((i + 1) % 4) == 3)) begin errors++; $display("FAIL up_equ0 step %0d: got %b required %b", i, bus.EQU0, ((i + 1) % 4) == 3); end
            checks++; if (bus.TAIFGset !== e_ifg) begin errors++; $display("FAIL up_taifg step %0d: got %b required %b", i, bus.TAIFGset, e_ifg); end
        end
    endtask

    task automatic test_continuous();
        int ifg_cnt;
        int equ_cnt;
        logic [15:0] seq [0:6];
        seq[0] = 16'hFFFF; seq[1] = 16'h0000; seq[2] = 16'h0001; seq[3] = 16'h0002;
        seq[4] = 16'h0003; seq[5] = 16'h0004; seq[6] = 16'h0005;
        ifg_cnt = 0;
        equ_cnt = 0;
        start(2'd2, 2'd0, 3'd0, 16'd5);
        bus.wTAR  = 1'b1;
        bus.TARin = 16'hFFFE;
        step();
        bus.wTAR  = 1'b0;
        checks++; if (bus.TAR !== 16'hFFFE) begin errors++; $display("FAIL cont_write: got %h required fffe", bus.TAR); end
        checks++; if (bus.EQU0 !== 1'b0 || bus.TAIFGset !== 1'b0) begin errors++; $display("FAIL cont_write_pulse: got %b%b required 00", bus.EQU0, bus.TAIFGset); end
        for (int i = 0; i < 7; i++) begin
            step();
            if (bus.TAIFGset === 1'b1) ifg_cnt++;
            if (bus.EQU0 === 1'b1) equ_cnt++;
            checks++; if (bus.TAR !== seq[i]) begin errors++; $display("FAIL cont_tar step %0d: got %h required %h", i, bus.TAR, seq[i]); end
            checks++; if (bus.TAIFGset !== (seq[i] == 16'h0000)) begin errors++; $display("FAIL cont_taifg step %0d: got %b required %b", i, bus.TAIFGset, seq[i] == 16'h0000); end
            checks++; if (bus.EQU0 !== (seq[i] == 16'h0005)) begin errors++; $display("FAIL cont_equ0 step %0d: got %b required %b", i, bus.EQU0, seq[i] == 16'h0005); end
        end
        checks++; if (ifg_cnt != 1) begin errors++; $display("FAIL cont_taifg_count: got %0d required 1", ifg_cnt); end
        checks++; if (equ_cnt != 1) begin errors++; $display("FAIL cont_equ0_count: got %0d required 1", equ_cnt); end
    endtask

    task automatic test_updown();
        int tar_seq [0:7];
        bit dir_seq [0:7];
        tar_seq = '{1, 2, 1, 0, 1, 2, 1, 0};
        dir_seq = '{1, 0, 0, 1, 1, 0, 0, 1};
        start(2'd3, 2'd0, 3'd0, 16'd2);
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (bus.TAR !== 16'(tar_seq[i])) begin errors++; $display("FAIL updn_tar step %0d: got %0d required %0d", i, bus.TAR, tar_seq[i]); end
            checks++; if (bus.DIR !== dir_seq[i]) begin errors++; $display("FAIL updn_dir step %0d: got %b required %b", i, bus.DIR, dir_seq[i]); end
            checks++; if (bus.EQU0 !== (tar_seq[i] == 2)) begin errors++; $display("FAIL updn_equ0 step %0d: got %b required %b", i, bus.EQU0, tar_seq[i] == 2); end
            checks++; if (bus.TAIFGset !== (tar_seq[i] == 0)) begin errors++; $display("FAIL updn_taifg step %0d: got %b required %b", i, bus.TAIFGset, tar_seq[i] == 0); end
        end
    endtask

    task automatic test_divider();
        int equ_cnt;
        int prev;
        equ_cnt = 0;
        start(2'd1, 2'd1, 3'd2, 16'd2);
        prev = 0;
        for (int i = 1; i <= 36; i++) begin
            step();
            if (bus.EQU0 === 1'b1) equ_cnt++;
            checks++; if (bus.TAR !== 16'((i / 6) % 3)) begin errors++; $display("FAIL div_tar cycle %0d: got %0d required %0d", i, bus.TAR, (i / 6) % 3); end
            checks++; if (bus.EQU0 !== (((i % 6) == 0) && (((i / 6) % 3) == 2))) begin errors++; $display("FAIL div_equ0 cycle %0d: got %b required %b", i, bus.EQU0, ((i % 6) == 0) && (((i / 6) % 3) == 2)); end
            checks++; if (bus.TAIFGset !== e_ifg) begin errors++; $display("FAIL div_taifg cycle %0d: got %b required %b", i, bus.TAIFGset, e_ifg); end
            prev = int'(bus.TAR);
        end
        checks++; if (equ_cnt != 2) begin errors++; $display("FAIL div_equ0_count: got %0d required 2", equ_cnt); end
    endtask

    task automatic test_ccr0_lower_and_clear();
        start(2'd1, 2'd0, 3'd0, 16'd10);
        bus.wTAR  = 1'b1;
        bus.TARin = 16'd7;
        step();
        bus.wTAR  = 1'b0;
        checks++; if (bus.TAR !== 16'd7) begin errors++; $display("FAIL lower_write: got %0d required 7", bus.TAR); end
        bus.TACCR0 = 16'd4;
        step();
        checks++; if (bus.TAR !== 16'd0) begin errors++; $display("FAIL lower_roll: got %0d required 0", bus.TAR); end
        checks++; if (bus.EQU0 !== 1'b0) begin errors++; $display("FAIL lower_equ0: got %b required 0", bus.EQU0); end
        checks++; if (bus.TAIFGset !== 1'b0) begin errors++; $display("FAIL lower_taifg: got %b required 0", bus.TAIFGset); end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (bus.TAR !== 16'(i)) begin errors++; $display("FAIL lower_run step %0d: got %0d required %0d", i, bus.TAR, i); end
        end
        bus.TACLR = 1'b1;
        step();
        bus.TACLR = 1'b0;
        checks++; if (bus.TAR !== 16'd0) begin errors++; $display("FAIL clear_tar: got %0d required 0", bus.TAR); end
        checks++; if (bus.EQU0 !== 1'b0 || bus.TAIFGset !== 1'b0) begin errors++; $display("FAIL clear_pulse: got %b%b required 00", bus.EQU0, bus.TAIFGset); end
        checks++; if (bus.DIR !== 1'b1) begin errors++; $display("FAIL clear_dir: got %b required 1", bus.DIR); end
    endtask

    task automatic test_async_reset();
        int first;
        start(2'd3, 2'd0, 3'd0, 16'd6);
        for (int i = 0; i < 7; i++) step();
        checks++; if (bus.TAR !== 16'd5 || bus.DIR !== 1'b0) begin errors++; $display("FAIL arst_pre: got tar=%0d dir=%b required tar=5 dir=0", bus.TAR, bus.DIR); end
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if (bus.TAR !== 16'd0) begin errors++; $display("FAIL arst_tar: got %0d required 0", bus.TAR); end
        checks++; if (bus.DIR !== 1'b1) begin errors++; $display("FAIL arst_dir: got %b required 1", bus.DIR); end
        checks++; if (bus.EQU0 !== 1'b0 || bus.TAIFGset !== 1'b0) begin errors++; $display("FAIL arst_pulse: got %b%b required 00", bus.EQU0, bus.TAIFGset); end
        bus.MC     = 2'd1;
        bus.ID     = 2'd1;
        bus.IDEX   = 3'd2;
        bus.TACCR0 = 16'd100;
        @(negedge TimerClock);
        reset = 1'b0;
        first = 0;
        for (int i = 1; i <= 20 && first == 0; i++) begin
            step();
            if (bus.TAR !== 16'd0) first = i;
        end
        checks++; if (first != 6) begin errors++; $display("FAIL arst_first_tick: got cycle %0d required 6", first); end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 5; seg++) begin
            start(2'($urandom_range(1, 3)), 2'($urandom_range(0, 1)), 3'($urandom_range(0, 2)),
                  16'($urandom_range(0, 12)));
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 29) == 0) bus.MC = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 39) == 0) bus.TACCR0 = 16'($urandom_range(0, 12));
                bus.wTAR  = ($urandom_range(0, 49) == 0);
                bus.TARin = 16'($urandom_range(0, 15));
                step();
                bus.wTAR = 1'b0;
                checks++; if (bus.TAR !== 16'(m_tar)) begin errors++; $display("FAIL rnd_tar seg %0d cyc %0d: got %0d required %0d", seg, i, bus.TAR, m_tar); end
                checks++; if (bus.DIR !== m_dir) begin errors++; $display("FAIL rnd_dir seg %0d cyc %0d: got %b required %b", seg, i, bus.DIR, m_dir); end
                checks++; if (bus.EQU0 !== e_equ) begin errors++; $display("FAIL rnd_equ0 seg %0d cyc %0d: got %b required %b", seg, i, bus.EQU0, e_equ); end
                checks++; if (bus.TAIFGset !== e_ifg) begin errors++; $display("FAIL rnd_taifg seg %0d cyc %0d: got %b required %b", seg, i, bus.TAIFGset, e_ifg); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_continuous();
        test_updown();
        test_divider();
        test_ccr0_lower_and_clear();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
